avalon_mem_responder: RTL and testbench
=======================================

# avalon_mem_responder

Avalon memory-mapped responder (slave) memory serving the CPU's bus master: word-organised RAM with byte-enable writes, a programmable number of wait states driven through `waitrequest`, and a side preload port used by testbenches to load instruction words before the CPU runs. It sits opposite `top_level_CPU` on the address/read/write/waitrequest/writedata/byteenable/readdata bus and is the synthesizable, cycle-accurate replacement for the behavioural bench memory.

## Interface
- `ADDR_WIDTH`, 8: word-index bits; depth = 2^ADDR_WIDTH words.
- `WAIT_STATES`, 1: extra BUSY cycles per transfer (0..15).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  32  byte address from master.
- `read`  in  1  read command.
- `write`  in  1  write command.
- `writedata`  in  32  write word.
- `byteenable`  in  4  lane enables, bit i = writedata[8i+7:8i].
- `waitrequest`  out  1  high = command not yet accepted; master holds command.
- `readdata`  out  32  read word, valid in the cycle waitrequest drops for a read.
- `preload_en`  in  1  preload write strobe.
- `preload_addr`  in  ADDR_WIDTH  word index for preload.
- `preload_data`  in  32  preload word.
- `error`  out  1  one-cycle pulse on a faulty transfer.

## Operation
- FSM states IDLE, BUSY, ACK; reset -> IDLE, counter 0.
- Word index = (address - BASE_ADDR) >> 2. Valid iff address[1:0]==0 and index < 2^ADDR_WIDTH.
- IDLE: exactly one of read/write high and preload_en low -> load counter with WAIT_STATES; go BUSY if WAIT_STATES>0, else ACK.
- BUSY: decrement counter; at 1 -> ACK. If read and write both drop -> IDLE, error pulse, no memory change.
- ACK: transfer completes; write commits lanes with byteenable set on the edge leaving ACK; next state IDLE.
- `waitrequest` = (read|write) && state!=ACK, combinational; also high whenever preload_en is high.
- Read data registered on entry to ACK: mem[index] if valid, else 32'h0000_0000.
- Invalid address: transfer runs full FSM, write dropped, readdata 0, error pulses in ACK.
- read && write together in IDLE: no-op, waitrequest low same cycle, error pulses next cycle, readdata unchanged.
- byteenable==0 write: completes normally, memory unchanged, no error.
- Reads ignore byteenable; full word returned.
- preload_en: mem[preload_addr] <= preload_data every edge it is high; bus FSM frozen in its current state; preload has priority over bus write to the same word.

## Timing
- Reset values: waitrequest 0 (when no command), readdata 32'h0, error 0, state IDLE. Memory array is not reset.
- Transfer length = WAIT_STATES + 2 cycles from command assertion to acceptance edge (WAIT_STATES=1: IDLE, BUSY, ACK).
- Back-to-back: a command held after ACK restarts from IDLE on the next cycle; no pipelining, one outstanding transfer.
- Read-after-write to the same word returns the new value (write committed before the following IDLE).
- Reset asserted mid-transfer: immediate return to IDLE, pending write discarded, outputs to reset values.
- error is high for exactly one cycle per faulty transfer.

## Structure
- Package `avalon_mem_pkg`: FSM state enum, `BUS_READ_DEFAULT` (32'h0), wait-counter width constant (4).
- Sub-module `byte_lane_ram`: 2^ADDR_WIDTH x 32 array, 4 lane write enables, one synchronous write port shared by preload/bus via priority mux, asynchronous read.
- FSM, address decode and error logic in the top module.

## Test plan
- Preload 32'h24020010 at word 1, then bus read address 32'h4 (WAIT_STATES=1) -> waitrequest high 2 cycles, readdata 32'h24020010 on the third, error 0.
- Write 32'hAABBCCDD to 32'h8 with byteenable 4'b0101, then read -> 32'h00BB00DD from cleared word.
- WAIT_STATES=0: read -> exactly 1 wait cycle; WAIT_STATES=3 -> exactly 4.
- Read 32'h402 (misaligned) and 32'h400 (out of range, ADDR_WIDTH=8) -> readdata 0, error one-cycle pulse each, memory unchanged.
- read and write both high -> waitrequest low immediately, error pulse, no write.
- Assert reset during BUSY of a write to 32'hC -> state IDLE, word 3 keeps old value, outputs at reset values.

Source files
------------

// File: rtl/avalon_mem_pkg.sv
// Shared types and constants for the Avalon responder memory.
// State encoding, wait-counter width and bus defaults live here.
package avalon_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [31:0] BUS_READ_DEFAULT = 32'h0000_0000;
    localparam int          WAIT_CNT_W       = 4;
    localparam int          BYTE_LANES       = 4;

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte write lanes and asynchronous read.
// A single write port is shared; preload always wins over the bus.
module byte_lane_ram
    import avalon_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  preload_en,
    input  logic [ADDR_WIDTH-1:0] preload_addr,
    input  logic [31:0]           preload_data,
    input  logic [BYTE_LANES-1:0] bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [31:0]           bus_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [31:0]           read_data
);

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [BYTE_LANES-1:0] wr_lanes;

    always_comb begin
        wr_addr  = bus_addr;
        wr_data  = bus_data;
        wr_lanes = bus_we;
        if (preload_en) begin
            wr_addr  = preload_addr;
            wr_data  = preload_data;
            wr_lanes = '1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (wr_lanes[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM responder: IDLE/BUSY/ACK handshake with programmable wait states,
// address decode, fault signalling and a preload side port into byte_lane_ram.
module avalon_mem_responder
    import avalon_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    input  logic                  preload_en,
    input  logic [ADDR_WIDTH-1:0] preload_addr,
    input  logic [31:0]           preload_data,
    output logic                  error
);

    localparam logic [WAIT_CNT_W-1:0] WS_CNT = WAIT_CNT_W'(WAIT_STATES);

    state_t                state, state_next;
    logic [WAIT_CNT_W-1:0] count, count_next;
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] index;
    logic                  addr_valid;
    logic                  single_cmd, both_cmd, no_cmd;
    logic                  enter_ack, abort, err_next;
    logic [3:0]            bus_we;
    logic [31:0]           mem_rdata;

    assign offset     = address - BASE_ADDR;
    assign index      = offset[ADDR_WIDTH+1:2];
    assign addr_valid = (address[1:0] == 2'b00) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
    assign single_cmd = read ^ write;
    assign both_cmd   = read & write;
    assign no_cmd     = ~(read | write);

    // Readdata is captured only on the edge into ACK; error is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            readdata <= BUS_READ_DEFAULT;
            error    <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            error <= err_next;
            if (enter_ack && read && !write) begin
                readdata <= addr_valid ? mem_rdata : BUS_READ_DEFAULT;
            end
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        enter_ack  = 1'b0;
        abort      = 1'b0;
        if (!preload_en) begin
            unique case (state)
                IDLE: begin
                    if (single_cmd) begin
                        count_next = WS_CNT;
                        if (WS_CNT == '0) begin
                            state_next = ACK;
                            enter_ack  = 1'b1;
                        end else begin
                            state_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (no_cmd) begin
                        state_next = IDLE;
                        abort      = 1'b1;
                    end else begin
                        count_next = count - WAIT_CNT_W'(1);
                        if (count == WAIT_CNT_W'(1)) begin
                            state_next = ACK;
                            enter_ack  = 1'b1;
                        end
                    end
                end
                ACK:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A simultaneous read+write in IDLE is refused at once rather than stalled.
    always_comb begin
        waitrequest = preload_en ||
                      ((read || write) && (state != ACK) && !((state == IDLE) && both_cmd));
        bus_we = '0;
        if ((state == ACK) && !preload_en && write && addr_valid) begin
            bus_we = byteenable;
        end
        err_next = !preload_en &&
                   (((state == IDLE) && both_cmd) || abort || (enter_ack && !addr_valid));
    end

    byte_lane_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk         (clk),
        .preload_en  (preload_en),
        .preload_addr(preload_addr),
        .preload_data(preload_data),
        .bus_we      (bus_we),
        .bus_addr    (index),
        .bus_data    (writedata),
        .read_addr   (index),
        .read_data   (mem_rdata)
    );

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed self-checking bench for avalon_mem_responder (main instance WAIT_STATES=1,
// plus WAIT_STATES=0 and 3 instances sharing address/data/preload for latency checks).
module tb_avalon_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic        read = 1'b0, write = 1'b0;
    logic        read_ws0 = 1'b0, read_ws3 = 1'b0, no_write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic        preload_en = 1'b0;
    logic [7:0]  preload_addr = '0;
    logic [31:0] preload_data = '0;

    logic        waitrequest, waitrequest_ws0, waitrequest_ws3;
    logic [31:0] readdata, readdata_ws0, readdata_ws3;
    logic        error, error_ws0, error_ws3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avalon_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .preload_en(preload_en), .preload_addr(preload_addr),
        .preload_data(preload_data), .error(error)
    );

    avalon_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_ws0 (
        .clk(clk), .reset(reset), .address(address), .read(read_ws0), .write(no_write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest_ws0),
        .readdata(readdata_ws0), .preload_en(preload_en), .preload_addr(preload_addr),
        .preload_data(preload_data), .error(error_ws0)
    );

    avalon_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut_ws3 (
        .clk(clk), .reset(reset), .address(address), .read(read_ws3), .write(no_write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest_ws3),
        .readdata(readdata_ws3), .preload_en(preload_en), .preload_addr(preload_addr),
        .preload_data(preload_data), .error(error_ws3)
    );

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        preload_en = 1'b1; preload_addr = addr; preload_data = data;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    // One bus transfer on the main instance; samples every cycle 1 time unit after the falling edge.
    task automatic do_xfer(input logic is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rdata, output int waits,
                           output int errs, output bit tmo);
        waits = 0; errs = 0; tmo = 1'b1; rdata = '0;
        @(negedge clk);
        address = addr; writedata = wdata; byteenable = be; read = !is_wr; write = is_wr;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (error) errs++;
            if (!waitrequest) begin
                rdata = readdata;
                tmo = 1'b0;
                break;
            end
            waits++;
            @(negedge clk);
        end
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        #1;
        if (error) errs++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (waitrequest !== 1'b0 || readdata !== 32'h0 || error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got wr=%b rd=%h err=%b, want 0 00000000 0",
                     waitrequest, readdata, error);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_preload_read;
        logic [31:0] rd; int waits, errs; bit tmo;
        @(negedge clk);
        preload_en = 1'b1; preload_addr = 8'd1; preload_data = 32'h2402_0010;
        #1;
        n_checks++;
        if (waitrequest !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL preload_waitrequest: got %b want 1", waitrequest);
        end
        @(negedge clk);
        preload_en = 1'b0;
        do_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || waits !== 2 || rd !== 32'h2402_0010 || errs !== 0) begin
            n_fail++;
            $display("[TB] FAIL preload_read: got tmo=%0d waits=%0d data=%h errs=%0d, want 0 2 24020010 0",
                     tmo, waits, rd, errs);
        end
    endtask

    task automatic test_byte_enable;
        logic [31:0] rd; int waits, errs; bit tmo;
        preload(8'd2, 32'h0);
        do_xfer(1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || waits !== 2 || errs !== 0) begin
            n_fail++;
            $display("[TB] FAIL be_write: got tmo=%0d waits=%0d errs=%0d, want 0 2 0", tmo, waits, errs);
        end
        do_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || rd !== 32'h00BB_00DD) begin
            n_fail++;
            $display("[TB] FAIL be_readback: got tmo=%0d data=%h, want 0 00bb00dd", tmo, rd);
        end
    endtask

    task automatic test_wait_states;
        int waits; bit done;
        waits = 0; done = 1'b0;
        @(negedge clk);
        address = 32'h4; read_ws0 = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!waitrequest_ws0) done = 1'b1;
            else begin waits++; @(negedge clk); end
        end
        n_checks++;
        if (!done || waits !== 1 || readdata_ws0 !== 32'h2402_0010) begin
            n_fail++;
            $display("[TB] FAIL ws0_latency: got done=%0d waits=%0d data=%h, want 1 1 24020010",
                     done, waits, readdata_ws0);
        end
        @(negedge clk);
        read_ws0 = 1'b0;
        waits = 0; done = 1'b0;
        @(negedge clk);
        read_ws3 = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!waitrequest_ws3) done = 1'b1;
            else begin waits++; @(negedge clk); end
        end
        n_checks++;
        if (!done || waits !== 4 || readdata_ws3 !== 32'h2402_0010) begin
            n_fail++;
            $display("[TB] FAIL ws3_latency: got done=%0d waits=%0d data=%h, want 1 4 24020010",
                     done, waits, readdata_ws3);
        end
        @(negedge clk);
        read_ws3 = 1'b0;
    endtask

    // Write then read the same word with no idle gap between the two commands.
    task automatic test_back_to_back;
        int waits; bit done;
        waits = 0; done = 1'b0;
        @(negedge clk);
        address = 32'h10; writedata = 32'h5A5A_5A5A; byteenable = 4'hF; write = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!waitrequest) done = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        write = 1'b0; read = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!waitrequest) done = 1'b1;
            else begin waits++; @(negedge clk); end
        end
        n_checks++;
        if (!done || waits !== 2 || readdata !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_raw: got done=%0d waits=%0d data=%h, want 1 2 5a5a5a5a",
                     done, waits, readdata);
        end
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic test_zero_byteenable;
        logic [31:0] rd; int waits, errs; bit tmo;
        do_xfer(1'b1, 32'h10, 32'h0, 4'b0000, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || waits !== 2 || errs !== 0) begin
            n_fail++;
            $display("[TB] FAIL be0_write: got tmo=%0d waits=%0d errs=%0d, want 0 2 0", tmo, waits, errs);
        end
        do_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || rd !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("[TB] FAIL be0_readback: got tmo=%0d data=%h, want 0 5a5a5a5a", tmo, rd);
        end
    endtask

    task automatic test_invalid_address;
        logic [31:0] rd; int waits, errs; bit tmo;
        preload(8'd0, 32'h0BAD_F00D);
        do_xfer(1'b0, 32'h402, 32'h0, 4'h0, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || waits !== 2 || rd !== 32'h0 || errs !== 1) begin
            n_fail++;
            $display("[TB] FAIL misaligned_read: got tmo=%0d waits=%0d data=%h errs=%0d, want 0 2 00000000 1",
                     tmo, waits, rd, errs);
        end
        do_xfer(1'b0, 32'h400, 32'h0, 4'h0, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || rd !== 32'h0 || errs !== 1) begin
            n_fail++;
            $display("[TB] FAIL range_read: got tmo=%0d data=%h errs=%0d, want 0 00000000 1", tmo, rd, errs);
        end
        do_xfer(1'b1, 32'h400, 32'hDEAD_BEEF, 4'hF, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || errs !== 1) begin
            n_fail++;
            $display("[TB] FAIL range_write: got tmo=%0d errs=%0d, want 0 1", tmo, errs);
        end
        do_xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || rd !== 32'h0BAD_F00D || errs !== 0) begin
            n_fail++;
            $display("[TB] FAIL range_no_alias: got tmo=%0d data=%h errs=%0d, want 0 0badf00d 0", tmo, rd, errs);
        end
    endtask

    task automatic test_read_write_conflict;
        logic [31:0] rd; int waits, errs; bit tmo;
        preload(8'd5, 32'h1111_2222);
        @(negedge clk);
        address = 32'h14; writedata = 32'hFFFF_FFFF; byteenable = 4'hF; read = 1'b1; write = 1'b1;
        #1;
        n_checks++;
        if (waitrequest !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL conflict_waitrequest: got %b want 0", waitrequest);
        end
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        #1;
        n_checks++;
        if (error !== 1'b1 || readdata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("[TB] FAIL conflict_error: got err=%b data=%h, want 1 0badf00d", error, readdata);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL conflict_pulse_width: got err=%b want 0", error);
        end
        do_xfer(1'b0, 32'h14, 32'h0, 4'h0, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || rd !== 32'h1111_2222) begin
            n_fail++;
            $display("[TB] FAIL conflict_no_write: got tmo=%0d data=%h, want 0 11112222", tmo, rd);
        end
    endtask

    task automatic test_abort;
        @(negedge clk);
        address = 32'h4; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (error !== 1'b1 || readdata !== 32'h1111_2222 || waitrequest !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_error: got err=%b data=%h wr=%b, want 1 11112222 0",
                     error, readdata, waitrequest);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_pulse_width: got err=%b want 0", error);
        end
    endtask

    task automatic test_reset_mid_transfer;
        logic [31:0] rd; int waits, errs; bit tmo;
        preload(8'd3, 32'h3333_4444);
        @(negedge clk);
        address = 32'hC; writedata = 32'h0; byteenable = 4'hF; write = 1'b1;
        @(negedge clk);
        reset = 1'b0; write = 1'b0;
        #1;
        n_checks++;
        if (waitrequest !== 1'b0 || readdata !== 32'h0 || error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got wr=%b rd=%h err=%b, want 0 00000000 0",
                     waitrequest, readdata, error);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, waits, errs, tmo);
        n_checks++;
        if (tmo || waits !== 2 || rd !== 32'h3333_4444) begin
            n_fail++;
            $display("[TB] FAIL midreset_word_kept: got tmo=%0d waits=%0d data=%h, want 0 2 33334444",
                     tmo, waits, rd);
        end
    endtask

    initial begin
        test_reset;
        test_preload_read;
        test_byte_enable;
        test_wait_states;
        test_back_to_back;
        test_zero_byteenable;
        test_invalid_address;
        test_read_write_conflict;
        test_abort;
        test_reset_mid_transfer;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
